// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
//
// Datapath of a multicycle MIPS processor. It holds the PC, the instruction
// register, the memory data register, the A/B operand latches, ALUOut and a
// 32-entry register file. It also contains the ALU, the sign extender and all
// datapath muxes. The controller FSM drives the control inputs and reads back
// Opcode, Funct and zero. One unified memory port is driven from here. The
// memory write strobe goes from the controller straight to the memory.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   MemToReg        register-file write data: 1 = MDR, 0 = ALUOut
//   RegDst          register-file write address: 1 = rd, 0 = rt
//   IorD            memory address: 1 = ALUOut, 0 = PC
//   PCSrc           next PC: 1 = ALUOut, 0 = ALUResult
//   ALUSrcA         ALU operand A: 1 = A register, 0 = PC
//   ALUSrcB[1:0]    ALU operand B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   IRWrite         load IR from mem_rd
//   PCWrite         unconditional PC load
//   Branch          PC load qualified by zero
//   RegWrite        register-file write enable
//   ALUControl[2:0] ALU operation
//   Opcode, Funct   IR[31:26] and IR[5:0], returned to the controller
//   zero            ALUResult == 0 (combinational)
//   mem_adr         memory address
//   mem_wd          memory write data (B register)
//   mem_rd          memory read data (combinational read of mem_adr)
// ---------------------------------------------------------------------------
module mc_datapath #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemToReg,
    input  logic             RegDst,
    input  logic             IorD,
    input  logic             PCSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic             IRWrite,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic             RegWrite,
    input  logic [2:0]       ALUControl,
    output logic [5:0]       Opcode,
    output logic [5:0]       Funct,
    output logic             zero,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] rf [32];

    logic [WIDTH-1:0] sign_imm;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] rf_wdata;
    logic [4:0]       rf_waddr;
    logic             pc_en;

    assign Opcode   = ir[31:26];
    assign Funct    = ir[5:0];
    assign sign_imm = {{(WIDTH-16){ir[15]}}, ir[15:0]};
    assign src_a    = ALUSrcA ? a_reg : pc;

    // Operand B selection. The shifted immediate is the word offset of a
    // branch, added to PC+4 during decode to form the branch target.
    always_comb begin
        src_b = b_reg;
        case (ALUSrcB)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = WIDTH'(4);
            2'b10:   src_b = sign_imm;
            default: src_b = {sign_imm[WIDTH-3:0], 2'b00};
        endcase
    end

    // ALU: arithmetic wraps, set-less-than is a signed compare, and unused
    // operation codes produce zero.
    always_comb begin
        alu_result = '0;
        case (ALUControl)
            3'b010:  alu_result = src_a + src_b;
            3'b110:  alu_result = src_a - src_b;
            3'b000:  alu_result = src_a & src_b;
            3'b001:  alu_result = src_a | src_b;
            3'b111:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero     = (alu_result == '0);
    assign pc_en    = PCWrite | (Branch & zero);
    assign pc_next  = PCSrc ? alu_out : alu_result;
    assign mem_adr  = IorD ? alu_out : pc;
    assign mem_wd   = b_reg;
    assign rf_waddr = RegDst ? ir[15:11] : ir[20:16];
    assign rf_wdata = MemToReg ? mdr : alu_out;

    // Architectural and pipeline-like latches. MDR, A, B and ALUOut reload
    // every cycle so each multicycle step sees the previous step's result.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (pc_en) begin
                pc <= pc_next;
            end
            if (IRWrite) begin
                ir <= mem_rd;
            end
            mdr     <= mem_rd;
            a_reg   <= rf[ir[25:21]];
            b_reg   <= rf[ir[20:16]];
            alu_out <= alu_result;
        end
    end

    // Register file write port. Entry 0 is never written, so it always reads
    // back zero. Reads are asynchronous and see the pre-write value on the
    // edge of a write, with no bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (RegWrite && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// ---------------------------------------------------------------------------
// tb_mc_datapath
//
// The bench acts as the multicycle controller and as the unified memory.
// Each pass loads a random program into memory. The program ends with a
// store of every register. An instruction-level reference model executes
// the program and queues the responses the datapath must show: the fetch
// address, the decoded fields, the branch compare flag and the store
// address/data. A monitor pops the queue whenever the controller marks an
// observable cycle.
// ---------------------------------------------------------------------------
module tb_mc_datapath;

    localparam int OBS_NONE   = 0;
    localparam int OBS_FETCH  = 1;
    localparam int OBS_DECODE = 2;
    localparam int OBS_ZERO   = 3;
    localparam int OBS_STORE  = 4;
    localparam int OBS_RESET  = 5;
    localparam int OBS_FINAL  = 6;

    localparam int RAND_END   = 50;
    localparam int PROG_END   = RAND_END + 32;
    localparam int DATA_BASE  = 512;
    localparam int MAX_INSTR  = 400;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemToReg, RegDst, IorD, PCSrc, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IRWrite, PCWrite, Branch, RegWrite;
    logic [2:0]  ALUControl;
    logic [5:0]  Opcode, Funct;
    logic        zero;
    logic [31:0] mem_adr, mem_wd, mem_rd;

    logic        memWrite;
    logic [31:0] mem [256];
    logic [31:0] modelMem [256];
    logic [31:0] regs [32];
    logic [31:0] mpc;
    logic [5:0]  functTable [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    exp_t        expQ [$];
    int          obsKind;
    logic        runaway;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_adr[9:2]];

    mc_datapath #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemToReg  (MemToReg),
        .RegDst    (RegDst),
        .IorD      (IorD),
        .PCSrc     (PCSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .RegWrite  (RegWrite),
        .ALUControl(ALUControl),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .zero      (zero),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    // Compare one observed value against the expected one and keep score.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Monitor: every cycle the controller marks as observable consumes one
    // queued expectation. The final mark confirms the queue drained and the
    // program ran to its end within the instruction budget.
    always @(negedge clk) begin
        exp_t e;
        if (obsKind == OBS_FINAL) begin
            checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
            checkOutput("program_completed", {31'd0, runaway}, 32'd0);
        end else if (obsKind != OBS_NONE) begin
            if (expQ.size() == 0) begin
                checkOutput("queue_underflow", 32'(obsKind), 32'd0);
            end else begin
                e = expQ.pop_front();
                case (e.kind)
                    OBS_FETCH: checkOutput("fetch_pc", mem_adr, e.a);
                    OBS_DECODE: begin
                        checkOutput("opcode", {26'd0, Opcode}, e.a);
                        checkOutput("funct", {26'd0, Funct}, e.b);
                    end
                    OBS_ZERO: checkOutput("branch_zero", {31'd0, zero}, e.a);
                    OBS_STORE: begin
                        checkOutput("store_adr", mem_adr, e.a);
                        checkOutput("store_data", mem_wd, e.b);
                    end
                    OBS_RESET: begin
                        checkOutput("reset_opcode", {26'd0, Opcode}, 32'd0);
                        checkOutput("reset_funct", {26'd0, Funct}, 32'd0);
                        checkOutput("reset_mem_wd", mem_wd, 32'd0);
                        checkOutput("reset_mem_adr", mem_adr, e.a);
                    end
                    default: checkOutput("unknown_kind", 32'(e.kind), 32'd0);
                endcase
            end
        end
    end

    function automatic logic [31:0] encR(input int rs, input int rt, input int rd,
                                         input logic [5:0] f);
        logic [4:0] s, t, d;
        s = rs[4:0];
        t = rt[4:0];
        d = rd[4:0];
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0];
        t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    function automatic logic [2:0] aluCodeFor(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic pushExp(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        expQ.push_back(e);
    endtask

    task automatic clearControls();
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = 3'b000;
        memWrite   = 1'b0;
    endtask

    // One clock cycle with the currently driven controls. The memory write
    // is captured mid-cycle and applied at the edge, like a synchronous RAM.
    task automatic tick(input int obs);
        logic        doWrite;
        logic [31:0] wAdr, wData;
        obsKind = obs;
        @(negedge clk);
        doWrite = memWrite;
        wAdr    = mem_adr;
        wData   = mem_wd;
        @(posedge clk);
        if (doWrite) begin
            mem[wAdr[9:2]] = wData;
        end
        #1;
        obsKind = OBS_NONE;
        clearControls();
    endtask

    task automatic driveFetch(input int obs);
        ALUSrcB    = 2'b01;
        ALUControl = 3'b010;
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        tick(obs);
    endtask

    task automatic writeReg(input int r, input logic [31:0] v);
        if (r != 0) begin
            regs[r] = v;
        end
    endtask

    // Build a program: an optional directed prefix, random instructions with
    // forward-only branches, then a store of every register to data memory.
    task automatic buildProgram(input int pass);
        int first;
        int off;
        int kind;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        first = 0;
        if (pass == 0) begin
            mem[0] = encI(6'd8, 0, 1, 16'hFFFF);
            mem[1] = encI(6'd8, 0, 2, 16'h0001);
            mem[2] = encR(1, 2, 3, 6'h2A);
            mem[3] = encI(6'd4, 1, 1, 16'h0001);
            mem[4] = encI(6'd8, 0, 5, 16'h0007);
            mem[5] = encI(6'd4, 1, 2, 16'h0001);
            mem[6] = encR(1, 1, 0, 6'h20);
            first  = 7;
        end
        for (int i = first; i < RAND_END; i++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                4, 5: mem[i] = encI(6'd8, int'($urandom_range(0, 31)),
                                    int'($urandom_range(0, 31)), 16'($urandom));
                6: mem[i] = encI(6'd35, 0, int'($urandom_range(0, 31)),
                                 16'(DATA_BASE + 4 * int'($urandom_range(0, 31))));
                7: mem[i] = encI(6'd43, 0, int'($urandom_range(0, 31)),
                                 16'(DATA_BASE + 4 * int'($urandom_range(0, 31))));
                8: begin
                    off = int'($urandom_range(0, 3));
                    if (off > RAND_END - 1 - i) off = RAND_END - 1 - i;
                    mem[i] = encI(6'd4, int'($urandom_range(0, 31)),
                                  int'($urandom_range(0, 31)), 16'(off));
                end
                default: mem[i] = encR(int'($urandom_range(0, 31)),
                                       int'($urandom_range(0, 31)),
                                       int'($urandom_range(0, 31)),
                                       functTable[$urandom_range(0, 4)]);
            endcase
        end
        for (int r = 0; r < 32; r++) begin
            mem[RAND_END + r] = encI(6'd43, 0, r, 16'(DATA_BASE + 4 * r));
        end
    endtask

    // Issue one instruction: the reference model computes its architectural
    // effect and queues the expected responses, then the controller cycles
    // are driven.
    task automatic applyStimulus();
        logic [31:0] ins, imm, rsV, rtV, res, addr, nextPc;
        logic [5:0]  op, f;
        int          rs, rt, rd;
        ins    = modelMem[mpc[9:2]];
        op     = ins[31:26];
        f      = ins[5:0];
        rs     = int'(ins[25:21]);
        rt     = int'(ins[20:16]);
        rd     = int'(ins[15:11]);
        imm    = {{16{ins[15]}}, ins[15:0]};
        rsV    = regs[rs];
        rtV    = regs[rt];
        nextPc = mpc + 32'd4;

        pushExp(OBS_FETCH, mpc, 32'd0);
        pushExp(OBS_DECODE, {26'd0, op}, {26'd0, f});
        driveFetch(OBS_FETCH);
        ALUSrcB    = 2'b11;
        ALUControl = 3'b010;
        tick(OBS_DECODE);

        case (op)
            6'd0: begin
                case (f)
                    6'h20:   res = rsV + rtV;
                    6'h22:   res = rsV - rtV;
                    6'h24:   res = rsV & rtV;
                    6'h25:   res = rsV | rtV;
                    default: res = ($signed(rsV) < $signed(rtV)) ? 32'd1 : 32'd0;
                endcase
                writeReg(rd, res);
                ALUSrcA    = 1'b1;
                ALUControl = aluCodeFor(f);
                tick(OBS_NONE);
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                tick(OBS_NONE);
            end
            6'd8: begin
                writeReg(rt, rsV + imm);
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                tick(OBS_NONE);
                RegWrite = 1'b1;
                tick(OBS_NONE);
            end
            6'd35: begin
                addr = rsV + imm;
                writeReg(rt, modelMem[addr[9:2]]);
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                tick(OBS_NONE);
                IorD = 1'b1;
                tick(OBS_NONE);
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                tick(OBS_NONE);
            end
            6'd43: begin
                addr = rsV + imm;
                pushExp(OBS_STORE, addr, rtV);
                modelMem[addr[9:2]] = rtV;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                tick(OBS_NONE);
                IorD     = 1'b1;
                memWrite = 1'b1;
                tick(OBS_STORE);
            end
            default: begin
                pushExp(OBS_ZERO, (rsV == rtV) ? 32'd1 : 32'd0, 32'd0);
                if (rsV == rtV) begin
                    nextPc = mpc + 32'd4 + (imm << 2);
                end
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                Branch     = 1'b1;
                PCSrc      = 1'b1;
                tick(OBS_ZERO);
            end
        endcase
        mpc = nextPc;
    endtask

    initial begin
        int count;
        clearControls();
        obsKind = OBS_NONE;
        runaway = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                // Abandon the current instruction part-way, then reset with
                // every enable asserted; none of them may take effect.
                driveFetch(OBS_NONE);
                MemToReg   = 1'b1;
                RegDst     = 1'b1;
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                Branch     = 1'b1;
                RegWrite   = 1'b1;
                ALUSrcB    = 2'($urandom);
                ALUControl = 3'($urandom);
            end
            buildProgram(pass);
            reset = 1'b1;
            tick(OBS_NONE);
            reset = 1'b0;
            pushExp(OBS_RESET, 32'h0000_0000, 32'd0);
            tick(OBS_RESET);

            for (int i = 0; i < 32; i++) regs[i] = 32'd0;
            for (int i = 0; i < 256; i++) modelMem[i] = mem[i];
            mpc   = 32'h0000_0000;
            count = 0;
            while ((mpc < 32'(4 * PROG_END)) && (count < MAX_INSTR)) begin
                applyStimulus();
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    ALUControl = 3'($urandom);
                    tick(OBS_NONE);
                end
                count++;
            end
            if (count >= MAX_INSTR) runaway = 1'b1;
        end
        tick(OBS_FINAL);
        tick(OBS_NONE);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle MIPS datapath that consumes the control outputs of the multicycle controller FSM and returns Opcode, Funct and zero to it. Holds the architectural and non-architectural state: PC, instruction register, memory data register, A/B operand latches, ALUOut and a 32-entry register file. It also contains the ALU, the sign extender and all datapath muxes. Drives one unified instruction/data memory port; the controller's MemWrite goes to the memory directly and does not enter this block.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, PC value after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemToReg  in  1  register-file write data select: 1 = MDR, 0 = ALUOut.
- RegDst  in  1  register-file write address select: 1 = IR[15:11] (rd), 0 = IR[20:16] (rt).
- IorD  in  1  memory address select: 1 = ALUOut, 0 = PC.
- PCSrc  in  1  next-PC select: 1 = ALUOut, 0 = ALUResult.
- ALUSrcA  in  1  ALU operand A select: 1 = A register, 0 = PC.
- ALUSrcB  in  2  ALU operand B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- IRWrite  in  1  load IR from mem_rd.
- PCWrite  in  1  unconditional PC load.
- Branch  in  1  PC load qualified by zero.
- RegWrite  in  1  register-file write enable.
- ALUControl  in  3  ALU operation select.
- Opcode  out  6  IR[31:26].
- Funct  out  6  IR[5:0].
- zero  out  1  (ALUResult == 0); combinational.
- mem_adr  out  32  memory address; combinational from IorD.
- mem_wd  out  32  memory write data; equals the B register.
- mem_rd  in  32  memory read data; combinational read of mem_adr, sampled on the same edge.

## Operation
**Reset**
- Reset is synchronous and active-high.
- On the edge where reset = 1: PC←RESET_PC; IR, MDR, A, B and ALUOut←0; all 32 register-file entries←0.
- Control inputs are ignored on a reset edge.
- After reset: Opcode = 0, Funct = 0, mem_wd = 0, mem_adr = RESET_PC when IorD = 0.

**Derived values**
- SignImm = {{16{IR[15]}}, IR[15:0]}.
- PCEn = PCWrite | (Branch & zero). When PCEn = 1, PC←(PCSrc ? ALUOut : ALUResult).
- If PCWrite and Branch&zero are both true, the PC loads once, with the same value.

**Per-edge register updates**
- IR←mem_rd only when IRWrite = 1.
- MDR←mem_rd every cycle.
- A←RF[IR[25:21]] and B←RF[IR[20:16]] every cycle.
- ALUOut←ALUResult every cycle.

**Register file**
- Two asynchronous read ports, one synchronous write port.
- On RegWrite, RF[RegDst ? rd : rt]←(MemToReg ? MDR : ALUOut).
- Writes to register 0 are discarded; register 0 always reads 0.
- A write and a read of the same register in the same cycle: A/B capture the old value. No bypass.

**ALU** (32-bit, wraps mod 2^32, no overflow flag)
- 010 add; 110 sub; 000 and; 001 or.
- 111 slt: signed compare, result 1 or 0.
- Any other code: result 0.

## Timing
- No internal FSM; sequencing is set entirely by the controller. Every input affects state only at the next edge.
- Fetch cycle (IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUControl = 010, IRWrite = 1, PCWrite = 1): IR←M[PC] and PC←PC+4 on the same edge.
- LW takes 5 cycles, fetch to writeback:
  - Decode cycle: A/B latched.
  - MemAdr cycle: ALUOut←A+SignImm.
  - MemRead cycle: mem_adr = ALUOut; MDR latched.
  - Writeback cycle: RF[rt]←MDR.
- SW takes 4 cycles. In the MemWrite cycle, mem_adr = ALUOut and mem_wd = B, with B captured in decode.
- Holding all enables low leaves PC, IR and the RF unchanged indefinitely. MDR, A, B and ALUOut keep reloading.
- Reset asserted mid-instruction clears all state on that edge. The next fetch reads from RESET_PC.

## Test plan
- Reset with RF/IR preloaded non-zero → PC = 0, Opcode = 0, mem_wd = 0, and every RF register reads 0.
- Fetch with mem_rd = 32'h8C08_0004 (lw $8,4($0)) → IR = 32'h8C08_0004, Opcode = 6'b100011, PC = 4 after one edge.
- Full LW: M[4] = 32'hDEAD_BEEF, then decode/MemAdr/MemRead/writeback controls → mem_adr = 4 in MemRead; RF[8] = 32'hDEAD_BEEF after the 5th edge.
- SW sw $8,8($0) with RF[8] = 32'h1234_5678 → in the MemWrite cycle mem_adr = 8 and mem_wd = 32'h1234_5678.
- Branch=1, PCWrite=0, ALUControl=110, A=B=5, PCSrc=1, ALUOut=32'h40 → zero = 1 and PC = 32'h40. With A=5, B=6 → zero = 0 and PC unchanged.
- RegWrite to register 0 with ALUOut = 32'hFFFF_FFFF → RF[0] still reads 0. slt with A = 32'hFFFF_FFFF, B = 1 → ALUResult = 1.
